fifo_led_reader: RTL and testbench
==================================

// Module: fifo_led_reader
// PURPOSE
//   Read-side consumer for the 8-bit push/pop FIFO. Drains one byte at a time
//   through the FIFO's pop/empty/data_out interface and shows each byte on the
//   board LEDs for a fixed number of clock cycles before fetching the next.
//   It replaces a direct data_out-to-LED tie-off, so each popped byte stays
//   visible for a defined time.
// PARAMETERS
//   HOLD_CYCLES  4   clock cycles each byte is held on led; must be >= 1
//                    (the board build overrides it, e.g. 12000000)
//   CNT_W        24  hold counter width; 2**CNT_W must be > HOLD_CYCLES-1
// PORTS
//   clk           in   1  system clock; all state updates on posedge
//   reset         in   1  asynchronous, active-low reset (0 = reset)
//   enable        in   1  1 = allowed to start a new fetch from the FIFO
//   fifo_empty    in   1  FIFO empty flag
//   fifo_data     in   8  FIFO data_out; valid in the cycle after a pop cycle
//   fifo_pop      out  1  pop strobe to FIFO; exactly one cycle per byte
//   led           out  8  byte currently displayed
//   busy          out  1  1 whenever state != IDLE
//   shown_count   out  8  number of bytes loaded to led, modulo 256
// BEHAVIOUR
//   Reset (reset=0, asynchronous): state=IDLE, fifo_pop=0, led=8'h00, busy=0,
//     shown_count=0, hold counter=0. All outputs come from registers or are
//     decoded from state only. No output depends combinationally on any input.
//   States: IDLE -> POP -> LOAD -> HOLD -> IDLE.
//   IDLE: if enable=1 and fifo_empty=0 at posedge, go to POP. Otherwise stay.
//   POP (1 cycle): fifo_pop=1 (decoded from state). Always go to LOAD.
//   LOAD (1 cycle): at its posedge, led<=fifo_data, counter<=HOLD_CYCLES-1,
//     shown_count<=shown_count+1. Go to HOLD.
//   HOLD: if counter==0 go to IDLE. Otherwise counter<=counter-1.
//     led is stable for exactly HOLD_CYCLES cycles in HOLD.
//   Per-byte period: 1 IDLE + 1 POP + 1 LOAD + HOLD_CYCLES cycles.
//     With back-to-back data the new led value appears every HOLD_CYCLES+3
//     cycles. The first led update is 3 cycles after the IDLE cycle that sees
//     fifo_empty=0.
//   Latency: a byte pushed into an empty FIFO reaches led no earlier than
//     3 cycles after fifo_empty falls (as seen in IDLE).
//   fifo_pop is never asserted unless fifo_empty=0 was sampled in the preceding
//     IDLE cycle. This block is the sole reader, so the FIFO cannot empty
//     between IDLE and POP. fifo_pop is never asserted on consecutive cycles.
//   enable is sampled only in IDLE. Dropping enable in POP/LOAD/HOLD does not
//     abort the transfer. The current byte completes its hold, then the block
//     waits in IDLE.
//   led keeps its last value while in IDLE. It changes only in LOAD or on reset.
//   shown_count wraps 8'hFF -> 8'h00 with no flag.
//   HOLD_CYCLES=1: HOLD lasts 1 cycle, so the period is 4 cycles.
//   Reset mid-operation: immediate return to reset values. A byte already
//     popped but not yet loaded is discarded (the FIFO is reset together with
//     this block in the system).
// TESTING
//   1 reset=0 for 3 cycles with fifo_empty=0 -> fifo_pop stays 0, led=00,
//     busy=0, shown_count=0.
//   2 push A5 into the FIFO model, enable=1, HOLD_CYCLES=4 -> one fifo_pop
//     pulse, led=A5 3 cycles after fifo_empty falls, held 4 cycles,
//     shown_count=1, then IDLE with led still A5.
//   3 preload 01,02,03, enable=1 -> led shows 01,02,03, each change
//     7 cycles apart, exactly 3 pop pulses (no two adjacent),
//     shown_count=3, no pop after fifo_empty=1.
//   4 enable=0 with data present -> no pop for 20 cycles. Raise enable and
//     drop it in HOLD -> the current byte finishes, no further pop.
//   5 assert reset during LOAD -> led=00, busy=0, fifo_pop=0 in the same
//     cycle (asynchronous). After release with data present -> normal
//     fetch resumes.
//   6 stream 257 bytes -> shown_count wraps to 01, and led equals the last
//     byte pushed.

Source files
------------

// File: rtl/fifo_led_reader.sv
// fifo_led_reader: drains an 8-bit push/pop FIFO one byte at a time and holds
// each popped byte on the LEDs for HOLD_CYCLES clocks before fetching the next.
// Every output is a register or a decode of the state register only.
module fifo_led_reader #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_pop,
  output logic [7:0] led,
  output logic       busy,
  output logic [7:0] shown_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_LOAD = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Counter reload: HOLD_CYCLES-1 down to 0 inclusive gives HOLD_CYCLES cycles.
  localparam logic [CNT_W-1:0] LP_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [7:0]       r_led;
  logic [7:0]       r_shown;
  logic             w_hold_done;
  logic             w_load;

  assign w_hold_done = (r_hold_cnt == '0);
  assign w_load      = (r_state == ST_LOAD);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; enable is only consulted in IDLE so a started
  // transfer always runs to the end of its hold.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (enable && !fifo_empty) w_state_nxt = ST_POP;
      ST_POP:  w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = ST_HOLD;
      ST_HOLD: if (w_hold_done) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Hold counter: reloaded as the byte is loaded, counts down while holding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold_cnt <= '0;
    end else if (w_load) begin
      r_hold_cnt <= LP_HOLD_LAST;
    end else if ((r_state == ST_HOLD) && !w_hold_done) begin
      r_hold_cnt <= r_hold_cnt - 1'b1;
    end
  end

  // LED byte and shown counter update only in LOAD; FIFO data_out is valid
  // in the cycle after the pop strobe, which is exactly the LOAD cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led   <= '0;
      r_shown <= '0;
    end else if (w_load) begin
      r_led   <= fifo_data;
      r_shown <= r_shown + 8'd1;
    end
  end

  assign fifo_pop    = (r_state == ST_POP);
  assign busy        = (r_state != ST_IDLE);
  assign led         = r_led;
  assign shown_count = r_shown;

endmodule

// File: tb/tb_fifo_led_reader.sv
// Bench for fifo_led_reader: a queue-based FIFO feeds the DUT, a timeline
// model predicts every output each cycle, and directed phases pin key timings.
module tb_fifo_led_reader;

  localparam int H = 4;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_pop;
  logic [7:0] led;
  logic       busy;
  logic [7:0] shown_count;

  logic       fifo_rst_n;
  logic       push_v;
  logic [7:0] push_d;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_led_reader #(.HOLD_CYCLES(H), .CNT_W(24)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_pop    (fifo_pop),
    .led         (led),
    .busy        (busy),
    .shown_count (shown_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO environment: pop returns data on the next cycle, unbounded depth.
  byte unsigned fq[$];
  always @(posedge clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      fq.delete();
      fifo_data  <= 8'h00;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_pop && fq.size() > 0) fifo_data <= fq.pop_front();
      if (push_v) fq.push_back(push_d);
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Reference: a transfer is a fixed timeline of H+2 busy cycles after the
  // IDLE decision: pop in the first, byte captured at the end of the second.
  int         m_left  = 0;
  logic [7:0] m_led   = 8'h00;
  int         m_cnt   = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left = 0;
      m_led  = 8'h00;
      m_cnt  = 0;
    end else if (m_left == 0) begin
      if (enable && !fifo_empty) m_left = H + 2;
    end else begin
      if (m_left == H + 1) begin
        m_led = fifo_data;
        m_cnt = (m_cnt + 1) % 256;
      end
      m_left--;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Per-cycle compare plus event monitor (pop count, adjacency, led changes).
  int         pop_cnt    = 0;
  int         adj_cnt    = 0;
  logic       prev_pop   = 1'b0;
  logic       prev_empty = 1'b1;
  logic [7:0] prev_led   = 8'h00;
  int         t_fall     = 0;
  int         led_t[$];
  always @(negedge clk) begin
    check("pop",   int'(fifo_pop),    int'(m_left == H + 2));
    check("busy",  int'(busy),        int'(m_left != 0));
    check("led",   int'(led),         int'(m_led));
    check("shown", int'(shown_count), m_cnt);
    if (fifo_pop) pop_cnt++;
    if (fifo_pop && prev_pop) adj_cnt++;
    prev_pop = fifo_pop;
    if (prev_empty && !fifo_empty) t_fall = cyc;
    prev_empty = fifo_empty;
    if (led != prev_led) led_t.push_back(cyc);
    prev_led = led;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    push_d = b;
    push_v = 1'b1;
    step(1);
    push_v = 1'b0;
  endtask

  int         p0;
  int         k;
  logic [7:0] last_b;

  initial begin
    reset      = 1'b1;
    fifo_rst_n = 1'b1;
    enable     = 1'b0;
    push_v     = 1'b0;
    push_d     = 8'h00;
    #2;
    reset      = 1'b0;
    fifo_rst_n = 1'b0;
    step(2);

    // 1: reset held with a non-empty FIFO.
    fifo_rst_n = 1'b1;
    push(8'h77);
    step(3);
    check("t1_empty", int'(fifo_empty), 0);
    check("t1_pop",   int'(fifo_pop),   0);
    check("t1_led",   int'(led),        8'h00);
    check("t1_busy",  int'(busy),       0);
    check("t1_shown", int'(shown_count), 0);
    fifo_rst_n = 1'b0;
    step(1);
    fifo_rst_n = 1'b1;
    reset      = 1'b1;
    step(2);

    // 2: single byte, led 3 cycles after empty falls.
    p0 = pop_cnt;
    led_t.delete();
    enable = 1'b1;
    push(8'hA5);
    step(12);
    check("t2_pops",   pop_cnt - p0, 1);
    check("t2_nchg",   led_t.size(), 1);
    if (led_t.size() >= 1) check("t2_latency", led_t[0] - t_fall, 3);
    check("t2_led",    int'(led),        8'hA5);
    check("t2_shown",  int'(shown_count), 1);
    check("t2_busy",   int'(busy),       0);

    // 3: three preloaded bytes, changes 7 cycles apart.
    p0 = pop_cnt;
    led_t.delete();
    push(8'h01);
    push(8'h02);
    push(8'h03);
    step(30);
    check("t3_pops",  pop_cnt - p0, 3);
    check("t3_nchg",  led_t.size(), 3);
    if (led_t.size() == 3) begin
      check("t3_gap1", led_t[1] - led_t[0], 7);
      check("t3_gap2", led_t[2] - led_t[1], 7);
    end
    check("t3_led",   int'(led),         8'h03);
    check("t3_shown", int'(shown_count), 4);
    check("t3_adj",   adj_cnt, 0);

    // 4: enable low blocks fetches; dropping it in HOLD finishes the byte.
    enable = 1'b0;
    p0 = pop_cnt;
    push(8'h10);
    push(8'h11);
    step(20);
    check("t4_nopop", pop_cnt - p0, 0);
    check("t4_idle",  int'(busy), 0);
    enable = 1'b1;
    k = 0;
    while (led != 8'h10 && k < 50) begin
      step(1);
      k++;
    end
    check("t4_reach10", int'(led), 8'h10);
    enable = 1'b0;
    step(20);
    check("t4_pops",  pop_cnt - p0, 1);
    check("t4_led",   int'(led), 8'h10);
    check("t4_shown", int'(shown_count), 5);
    check("t4_busy",  int'(busy), 0);

    // 5: asynchronous reset during LOAD, then resume.
    enable = 1'b1;
    k = 0;
    while (!fifo_pop && k < 50) begin
      step(1);
      k++;
    end
    check("t5_popseen", int'(fifo_pop), 1);
    step(1);
    #2;
    reset      = 1'b0;
    fifo_rst_n = 1'b0;
    #1;
    check("t5_led",   int'(led),  8'h00);
    check("t5_busy",  int'(busy), 0);
    check("t5_pop",   int'(fifo_pop), 0);
    check("t5_shown", int'(shown_count), 0);
    step(1);
    reset      = 1'b1;
    fifo_rst_n = 1'b1;
    step(1);
    push(8'h22);
    step(12);
    check("t5_led_after",   int'(led), 8'h22);
    check("t5_shown_after", int'(shown_count), 1);

    // 6: 257-byte stream wraps shown_count.
    reset      = 1'b0;
    fifo_rst_n = 1'b0;
    step(1);
    reset      = 1'b1;
    fifo_rst_n = 1'b1;
    step(1);
    last_b = 8'h00;
    for (int i = 0; i < 257; i++) begin
      last_b = 8'((i * 7 + 3) & 8'hFF);
      push(last_b);
    end
    k = 0;
    while (!(fifo_empty && !busy) && k < 3000) begin
      step(1);
      k++;
    end
    check("t6_drained", int'(fifo_empty && !busy), 1);
    check("t6_shown",   int'(shown_count), 1);
    check("t6_led",     int'(led), int'(last_b));
    check("t6_adj",     adj_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
